hpdcache_gnt_mux_skid: RTL and testbench

- Downstream stage of the cache's fixed-priority arbiter.
- Consumes the arbiter's one-hot grant vector and selects the granted requester's payload.
- Buffers the selected payload in a 2-entry skid buffer and presents it on a valid/ready output.
- Drives the arbiter's ready input, so a grant is held stable while the buffer is full.

---
 rtl/hpdcache_gnt_mux_pkg.sv | 20 ++
 rtl/hpdcache_gnt_mux_skid_chk.sv | 13 +
 rtl/hpdcache_onehot_mux.sv | 27 ++
 rtl/hpdcache_gnt_mux_skid.sv | 177 +++++++++++++++++
 tb/tb_hpdcache_gnt_mux_skid.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/hpdcache_gnt_mux_pkg.sv
// Shared types and helpers for the grant-mux skid stage.
package hpdcache_gnt_mux_pkg;

    // Occupancy of the 2-entry skid buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

    // Width of a binary index that can address n requesters.
    function automatic int unsigned hpdcache_gnt_mux_idxw(input int unsigned n);
        if (n > 32'd1) begin
            return $clog2(n);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/hpdcache_gnt_mux_skid_chk.sv
// Protocol checker for the grant-mux skid stage: the grant must be
// one-hot or zero whenever the block is out of reset.
module hpdcache_gnt_mux_skid_chk #(
    parameter int unsigned N = 2
)(
    input logic         clk_i,
    input logic         rst_i,
    input logic [N-1:0] gnt_i
);

    a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_i));

endmodule

// File: rtl/hpdcache_onehot_mux.sv
// AND-OR payload selector driven by a one-hot-or-zero select vector.
// Produces the selected payload and the binary index of the set bit;
// both are zero when no bit is set.
module hpdcache_onehot_mux
    import hpdcache_gnt_mux_pkg::*;
#(
    parameter  int unsigned N    = 2,
    parameter  int unsigned W    = 32,
    localparam int unsigned IDXW = hpdcache_gnt_mux_idxw(N)
)(
    input  logic [N-1:0]    i_sel,
    input  logic [N*W-1:0]  i_data,
    output logic [W-1:0]    o_data,
    output logic [IDXW-1:0] o_idx
);

    // OR together every slice whose select bit is set.
    always_comb begin
        o_data = '0;
        o_idx  = '0;
        for (int k = 0; k < int'(N); k++) begin
            o_data = o_data | ({W{i_sel[k]}} & i_data[k*W +: W]);
            o_idx  = o_idx  | ({IDXW{i_sel[k]}} & IDXW'(k));
        end
    end

endmodule

// File: rtl/hpdcache_gnt_mux_skid.sv
// Grant-driven payload mux feeding a 2-entry skid buffer with a
// valid/ready output. arb_ready_o depends only on buffer state, so the
// arbiter never sees a combinational path from out_ready_i.
// Optional macro HPDCACHE_GNT_MUX_STATS_EN enables the stall counter.
// Defining HPDCACHE_ASSERT_OFF removes the grant protocol checker.
module hpdcache_gnt_mux_skid
    import hpdcache_gnt_mux_pkg::*;
#(
    parameter  int unsigned N    = 2,
    parameter  int unsigned W    = 32,
    localparam int unsigned IDXW = hpdcache_gnt_mux_idxw(N)
)(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req_valid_i,
    input  logic [N*W-1:0]  req_data_i,
    output logic [N-1:0]    req_ready_o,
    input  logic [N-1:0]    gnt_i,
    output logic            arb_ready_o,
    output logic            out_valid_o,
    output logic [W-1:0]    out_data_o,
    output logic [IDXW-1:0] out_src_o,
    input  logic            out_ready_i,
    output logic [31:0]     stall_cnt_o
);

    occ_state_e      r_state;
    occ_state_e      w_state_nxt;
    logic [W-1:0]    r_main_data;
    logic [IDXW-1:0] r_main_src;
    logic [W-1:0]    r_skid_data;
    logic [IDXW-1:0] r_skid_src;

    logic            w_main_valid;
    logic            w_skid_valid;
    logic            w_arb_ready;
    logic            w_gnt_valid;
    logic            w_push;
    logic            w_pop;
    logic            w_main_load;
    logic            w_main_from_skid;
    logic            w_skid_load;
    logic [W-1:0]    w_sel_data;
    logic [IDXW-1:0] w_sel_idx;

    hpdcache_onehot_mux #(
        .N (N),
        .W (W)
    ) u_sel (
        .i_sel  (gnt_i),
        .i_data (req_data_i),
        .o_data (w_sel_data),
        .o_idx  (w_sel_idx)
    );

    assign w_main_valid = (r_state != ST_EMPTY);
    assign w_skid_valid = (r_state == ST_FULL);
    assign w_arb_ready  = ~w_skid_valid;
    assign w_gnt_valid  = |(gnt_i & req_valid_i);
    assign w_push       = w_arb_ready & w_gnt_valid;
    assign w_pop        = w_main_valid & out_ready_i;

    assign arb_ready_o  = w_arb_ready;
    assign req_ready_o  = gnt_i & {N{w_arb_ready}};
    assign out_valid_o  = w_main_valid;
    assign out_data_o   = r_main_data;
    assign out_src_o    = r_main_src;

    // Next occupancy and which entry gets written this cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_nxt = ST_ONE;
                    w_main_load = 1'b1;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    w_state_nxt = ST_ONE;
                    w_main_load = 1'b1;
                end else if (w_push) begin
                    w_state_nxt = ST_FULL;
                    w_skid_load = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_ONE;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_state_nxt      = ST_ONE;
                    w_main_from_skid = 1'b1;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Occupancy state register; reset drops any buffered payload.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Main entry: loaded from the grant mux or promoted from skid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_main_data <= '0;
            r_main_src  <= '0;
        end else if (w_main_load) begin
            r_main_data <= w_sel_data;
            r_main_src  <= w_sel_idx;
        end else if (w_main_from_skid) begin
            r_main_data <= r_skid_data;
            r_main_src  <= r_skid_src;
        end else begin
            r_main_data <= r_main_data;
            r_main_src  <= r_main_src;
        end
    end

    // Skid entry: data only, validity is carried by the state register.
    always_ff @(posedge clk_i) begin
        if (w_skid_load) begin
            r_skid_data <= w_sel_data;
            r_skid_src  <= w_sel_idx;
        end else begin
            r_skid_data <= r_skid_data;
            r_skid_src  <= r_skid_src;
        end
    end

`ifdef HPDCACHE_GNT_MUX_STATS_EN
    logic [31:0] r_stall_cnt;

    // Count cycles where a granted requester is held off by a full buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= 32'd0;
        end else if (w_gnt_valid && !w_arb_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = 32'd0;
`endif

`ifndef HPDCACHE_ASSERT_OFF
    hpdcache_gnt_mux_skid_chk #(
        .N (N)
    ) u_chk (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .gnt_i (gnt_i)
    );
`endif

endmodule

// File: tb/tb_hpdcache_gnt_mux_skid.sv
// Directed self-checking bench for hpdcache_gnt_mux_skid (N=4, W=32).
module tb_hpdcache_gnt_mux_skid;

    localparam int N = 4;
    localparam int W = 32;
`ifdef HPDCACHE_GNT_MUX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   gnt;
    logic           arb_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_ready;
    logic [31:0]    stall_cnt;

    int total = 0;
    int bad   = 0;

    hpdcache_gnt_mux_skid #(
        .N (N),
        .W (W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .gnt_i       (gnt),
        .arb_ready_o (arb_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_src_o   (out_src),
        .out_ready_i (out_ready),
        .stall_cnt_o (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [W-1:0] d);
        req_data[k*W +: W] = d;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_data  = '0;
        gnt       = 4'b0000;
        out_ready = 1'b0;
        tick();
        tick();
        // req_ready follows the grant while in reset (buffer is empty)
        gnt = 4'b0010;
        #1;
        check_val("rst_req_ready", 64'(req_ready), 64'h2);
        gnt = 4'b0000;
        rst = 1'b0;
        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'h0);
        check_val("rst_arb_ready", 64'(arb_ready), 64'h1);
        check_val("rst_out_data",  64'(out_data),  64'h0);
        check_val("rst_out_src",   64'(out_src),   64'h0);
        check_val("rst_stall",     64'(stall_cnt), 64'h0);

        // Single push from requester 2
        out_ready = 1'b1;
        set_req(2, 32'hA5A5_0002);
        gnt       = 4'b0100;
        req_valid = 4'b0100;
        #1;
        check_val("p1_req_ready", 64'(req_ready), 64'h4);
        tick();
        gnt       = 4'b0000;
        req_valid = 4'b0000;
        #1;
        check_val("p1_out_valid", 64'(out_valid), 64'h1);
        check_val("p1_out_data",  64'(out_data),  64'hA5A5_0002);
        check_val("p1_out_src",   64'(out_src),   64'h2);
        tick();
        check_val("p1_drain", 64'(out_valid), 64'h0);

        // Fill to FULL with output stalled, then hold for 5 stall cycles
        out_ready = 1'b0;
        set_req(0, 32'h11);
        gnt       = 4'b0001;
        req_valid = 4'b0001;
        #1;
        tick();
        set_req(0, 32'h22);
        tick();
        check_val("full_arb_ready", 64'(arb_ready), 64'h0);
        check_val("full_req_ready", 64'(req_ready), 64'h0);
        check_val("full_head",      64'(out_data),  64'h11);
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        check_val("stall_cnt5", 64'(stall_cnt), STATS ? 64'd5 : 64'd0);
        check_val("full_hold",  64'(arb_ready), 64'h0);
        gnt       = 4'b0000;
        req_valid = 4'b0000;
        out_ready = 1'b1;
        #1;
        check_val("drain0_valid", 64'(out_valid), 64'h1);
        check_val("drain0_data",  64'(out_data),  64'h11);
        tick();
        check_val("drain1_valid", 64'(out_valid), 64'h1);
        check_val("drain1_data",  64'(out_data),  64'h22);
        check_val("drain1_arb",   64'(arb_ready), 64'h1);
        tick();
        check_val("drain2_valid", 64'(out_valid), 64'h0);
        check_val("stall_kept",   64'(stall_cnt), STATS ? 64'd5 : 64'd0);

        // Streaming push+pop at one per cycle from requester 3
        gnt       = 4'b1000;
        req_valid = 4'b1000;
        for (int i = 1; i <= 8; i++) begin
            set_req(3, 32'(i));
            check_val("strm_arb", 64'(arb_ready), 64'h1);
            tick();
            check_val("strm_valid", 64'(out_valid), 64'h1);
            check_val("strm_data",  64'(out_data),  64'(i));
            check_val("strm_src",   64'(out_src),   64'h3);
        end
        gnt       = 4'b0000;
        req_valid = 4'b0000;
        tick();
        check_val("strm_end", 64'(out_valid), 64'h0);

        // Grant without valid: no push
        gnt = 4'b0001;
        #1;
        check_val("nv_req_ready", 64'(req_ready), 64'h1);
        tick();
        tick();
        check_val("nv_out_valid", 64'(out_valid), 64'h0);
        check_val("nv_arb_ready", 64'(arb_ready), 64'h1);
        gnt = 4'b0000;

        // Reset while FULL
        out_ready = 1'b0;
        set_req(1, 32'h33);
        gnt       = 4'b0010;
        req_valid = 4'b0010;
        #1;
        tick();
        set_req(1, 32'h44);
        tick();
        check_val("rf_arb_ready", 64'(arb_ready), 64'h0);
        tick();
        check_val("rf_stall", 64'(stall_cnt), STATS ? 64'd6 : 64'd0);
        rst       = 1'b1;
        gnt       = 4'b0000;
        req_valid = 4'b0000;
        tick();
        rst = 1'b0;
        #1;
        check_val("rf_out_valid", 64'(out_valid), 64'h0);
        check_val("rf_arb",       64'(arb_ready), 64'h1);
        check_val("rf_stall0",    64'(stall_cnt), 64'h0);
        check_val("rf_data0",     64'(out_data),  64'h0);
        tick();
        check_val("rf_stay_empty", 64'(out_valid), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
